// File: rtl/ahb_pkg.sv
// ahb_pkg: shared AHB-lite transfer types and default widths
package ahb_pkg;
    typedef enum logic [1:0] {IDLE = 2'b00, BUSY = 2'b01, NONSEQ = 2'b10, SEQ = 2'b11} htrans_t;
    typedef enum logic [1:0] {S_IDLE, S_ADDR, S_DATA} ahb_state_t;
    localparam int AHB_ADDR_W = 4;
    localparam int AHB_DATA_W = 32;
endpackage

// File: rtl/ahb_wait_timer.sv
// ahb_wait_timer: saturating wait-state counter flagging the TIMEOUT-th counted cycle
module ahb_wait_timer #(
    parameter int TIMEOUT = 16
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic en,
    output logic expired
);
    localparam int CW = $clog2(TIMEOUT + 1);
    logic [CW-1:0] cnt_q, cnt_d;
    always_comb begin
        cnt_d = clr ? '0 : (en && cnt_q != CW'(TIMEOUT)) ? cnt_q + 1'b1 : cnt_q;
    end
    // looks at the post-edge count so the master can abort on the very edge that reaches TIMEOUT
    assign expired = cnt_d == CW'(TIMEOUT);
    always_ff @(posedge clk) begin
        cnt_q <= rst ? '0 : cnt_d;
    end
endmodule

// File: rtl/ahb_master.sv
// ahb_master: single-outstanding AHB-lite master with data-phase wait-state timeout
module ahb_master import ahb_pkg::*; #(
    parameter int ADDR_W  = AHB_ADDR_W,
    parameter int DATA_W  = AHB_DATA_W,
    parameter int TIMEOUT = 16
) (
    input  logic              HCLK,
    input  logic              HRESET,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic              cmd_write,
    input  logic [ADDR_W-1:0] cmd_addr,
    input  logic [DATA_W-1:0] cmd_wdata,
    output logic              rsp_valid,
    output logic [DATA_W-1:0] rsp_rdata,
    output logic              rsp_err,
    output logic [ADDR_W-1:0] HADDR,
    output logic              HWRITE,
    output logic [1:0]        HTRANS,
    output logic [DATA_W-1:0] HWDATA,
    input  logic [DATA_W-1:0] HRDATA,
    input  logic              HREADY
);
    ahb_state_t        state_q, state_d;
    htrans_t           htrans_q, htrans_d;
    logic [ADDR_W-1:0] haddr_q, haddr_d;
    logic              hwrite_q, hwrite_d, cmd_ready_q, cmd_ready_d;
    logic [DATA_W-1:0] hwdata_q, hwdata_d, wdata_q, wdata_d, rsp_rdata_q, rsp_rdata_d;
    logic              rsp_valid_q, rsp_valid_d, rsp_err_q, rsp_err_d;
    logic              rdy, expired;
    // X or Z on HREADY must read as a wait state, never as ready
    assign rdy = HREADY === 1'b1;
    ahb_wait_timer #(.TIMEOUT(TIMEOUT)) u_timer (
        .clk(HCLK), .rst(HRESET), .clr(state_q != S_DATA),
        .en(state_q == S_DATA && !rdy), .expired(expired)
    );
    always_comb begin
        state_d     = state_q;
        htrans_d    = htrans_q;
        haddr_d     = haddr_q;
        hwrite_d    = hwrite_q;
        hwdata_d    = hwdata_q;
        wdata_d     = wdata_q;
        rsp_valid_d = 1'b0;
        rsp_rdata_d = rsp_rdata_q;
        rsp_err_d   = rsp_err_q;
        case (state_q)
            S_IDLE: if (cmd_valid && cmd_ready_q) begin
                state_d  = S_ADDR;
                htrans_d = NONSEQ;
                haddr_d  = cmd_addr;
                hwrite_d = cmd_write;
                wdata_d  = cmd_wdata;
            end
            S_ADDR: if (rdy) begin
                state_d  = S_DATA;
                htrans_d = IDLE;
                hwdata_d = hwrite_q ? wdata_q : '0;
            end
            S_DATA: if (rdy || expired) begin
                state_d     = S_IDLE;
                hwdata_d    = '0;
                rsp_valid_d = 1'b1;
                rsp_err_d   = !rdy;
                rsp_rdata_d = (rdy && !hwrite_q) ? HRDATA : '0;
            end
            default: state_d = S_IDLE;
        endcase
        cmd_ready_d = state_d == S_IDLE;
    end
    always_ff @(posedge HCLK) begin
        if (HRESET) begin
            state_q     <= S_IDLE;
            htrans_q    <= IDLE;
            haddr_q     <= '0;
            hwrite_q    <= 1'b0;
            hwdata_q    <= '0;
            wdata_q     <= '0;
            cmd_ready_q <= 1'b0;
            rsp_valid_q <= 1'b0;
            rsp_rdata_q <= '0;
            rsp_err_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            htrans_q    <= htrans_d;
            haddr_q     <= haddr_d;
            hwrite_q    <= hwrite_d;
            hwdata_q    <= hwdata_d;
            wdata_q     <= wdata_d;
            cmd_ready_q <= cmd_ready_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_rdata_q <= rsp_rdata_d;
            rsp_err_q   <= rsp_err_d;
        end
    end
    assign HTRANS    = htrans_q;
    assign HADDR     = haddr_q;
    assign HWRITE    = hwrite_q;
    assign HWDATA    = hwdata_q;
    assign cmd_ready = cmd_ready_q;
    assign rsp_valid = rsp_valid_q;
    assign rsp_rdata = rsp_rdata_q;
    assign rsp_err   = rsp_err_q;
endmodule

// File: tb/tb_ahb_master.sv
// tb_ahb_master: randomized self-checking bench with a cycle-count latency model
module tb_ahb_master;
    localparam int TMO = 4;
    logic        HCLK = 1'b0, HRESET = 1'b1;
    logic        cmd_valid = 1'b0, cmd_write = 1'b0, cmd_ready;
    logic [3:0]  cmd_addr = '0, HADDR;
    logic [31:0] cmd_wdata = '0, rsp_rdata, HWDATA, HRDATA, hrdata = '0;
    logic        rsp_valid, rsp_err, HWRITE, hready = 1'b1, rom_mode = 1'b0;
    logic [1:0]  HTRANS;
    int          checks = 0, failures = 0;

    function automatic logic [31:0] rom_f(input logic [3:0] a);
        return 32'hC0DE0000 | (32'(a) * 32'h0000_1111);
    endfunction

    // slave side: ROM lookup on the presented address, or a value the scenario chooses
    assign HRDATA = rom_mode ? rom_f(HADDR) : hrdata;

    ahb_master #(.ADDR_W(4), .DATA_W(32), .TIMEOUT(TMO)) dut (
        .HCLK(HCLK), .HRESET(HRESET), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_write(cmd_write), .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata),
        .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
        .HADDR(HADDR), .HWRITE(HWRITE), .HTRANS(HTRANS), .HWDATA(HWDATA),
        .HRDATA(HRDATA), .HREADY(hready)
    );

    always #5 HCLK = ~HCLK;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    task automatic tick();
        @(posedge HCLK);
        #1;
    endtask

    function automatic int exp_lat(input int wa, input int wd);
        return (wd < TMO) ? 3 + wa + wd : 2 + wa + TMO;
    endfunction

    task automatic run_cmd(input logic w, input logic [3:0] a, input logic [31:0] d,
                           input int wa, input int wd, input bit xz, input logic [31:0] rdat,
                           output int lat, output logic [31:0] rd, output logic er, output int perr);
        int n;
        perr = 0;
        n = 0;
        while (cmd_ready !== 1'b1 && n < 10) begin tick(); n++; end
        if (cmd_ready !== 1'b1) perr++;
        cmd_valid = 1'b1; cmd_write = w; cmd_addr = a; cmd_wdata = d; hready = 1'b1;
        tick();
        lat = 1;
        cmd_valid = 1'b0; cmd_addr = 4'($urandom); cmd_wdata = $urandom; cmd_write = 1'($urandom);
        for (int i = 0; i <= wa; i++) begin
            if (HTRANS !== 2'b10 || HADDR !== a || HWRITE !== w || cmd_ready !== 1'b0 || rsp_valid !== 1'b0) perr++;
            hready = (i == wa);
            tick();
            lat++;
        end
        if (HTRANS !== 2'b00 || HWDATA !== (w ? d : 32'h0) || HADDR !== a || HWRITE !== w) perr++;
        for (int j = 0; j < TMO + 2 && rsp_valid !== 1'b1; j++) begin
            if (j < wd) begin hready = xz ? 1'bz : 1'b0; hrdata = $urandom; end
            else begin hready = 1'b1; hrdata = rdat; end
            tick();
            lat++;
        end
        hready = 1'b1;
        rd = rsp_rdata;
        er = rsp_err;
        if (rsp_valid !== 1'b1 || cmd_ready !== 1'b1) perr++;
    endtask

    task automatic test_reset();
        HRESET = 1'b1;
        tick(); tick();
        checks++;
        if ({HTRANS, HADDR, HWRITE, HWDATA, cmd_ready, rsp_valid, rsp_rdata, rsp_err} !== '0) begin
            failures++;
            $display("FAIL reset_values: htrans=%b haddr=%h hwrite=%b hwdata=%h rdy=%b rv=%b rd=%h err=%b, want all 0",
                     HTRANS, HADDR, HWRITE, HWDATA, cmd_ready, rsp_valid, rsp_rdata, rsp_err);
        end
        HRESET = 1'b0;
        tick();
        checks++;
        if (cmd_ready !== 1'b1) begin failures++; $display("FAIL reset_release_ready: got %b want 1", cmd_ready); end
    endtask

    task automatic test_zero_wait_write();
        int lat, perr; logic [31:0] rd; logic er;
        run_cmd(1'b1, 4'h3, 32'hDEADBEEF, 0, 0, 1'b0, 32'h0, lat, rd, er, perr);
        checks++;
        if (lat !== 3 || perr !== 0 || rd !== 32'h0 || er !== 1'b0) begin
            failures++;
            $display("FAIL zero_wait_write: lat=%0d perr=%0d rd=%h err=%b want lat=3 perr=0 rd=0 err=0", lat, perr, rd, er);
        end
        tick();
        checks++;
        if (rsp_valid !== 1'b0 || rsp_err !== 1'b0) begin
            failures++; $display("FAIL rsp_pulse_width: rv=%b err=%b want 0 0", rsp_valid, rsp_err);
        end
    endtask

    task automatic test_read_wait();
        int lat, perr; logic [31:0] rd; logic er;
        run_cmd(1'b0, 4'h9, 32'h0, 0, 2, 1'b0, 32'h12345678, lat, rd, er, perr);
        checks++;
        if (lat !== 5 || perr !== 0 || rd !== 32'h12345678 || er !== 1'b0) begin
            failures++;
            $display("FAIL read_2_waits: lat=%0d perr=%0d rd=%h err=%b want lat=5 perr=0 rd=12345678 err=0", lat, perr, rd, er);
        end
        tick();
        checks++;
        if (rsp_rdata !== 32'h12345678) begin failures++; $display("FAIL rdata_hold: got %h want 12345678", rsp_rdata); end
    endtask

    task automatic test_timeout();
        int lat, perr; logic [31:0] rd; logic er;
        run_cmd(1'b0, 4'h5, 32'h0, 0, TMO + 1, 1'b1, 32'hFFFFFFFF, lat, rd, er, perr);
        checks++;
        if (lat !== 2 + TMO || perr !== 0 || rd !== 32'h0 || er !== 1'b1) begin
            failures++;
            $display("FAIL timeout: lat=%0d perr=%0d rd=%h err=%b want lat=%0d perr=0 rd=0 err=1", lat, perr, rd, er, 2 + TMO);
        end
        tick();
        checks++;
        if (rsp_valid !== 1'b0 || rsp_err !== 1'b1 || cmd_ready !== 1'b1) begin
            failures++; $display("FAIL timeout_after: rv=%b err=%b rdy=%b want 0 1 1", rsp_valid, rsp_err, cmd_ready);
        end
    endtask

    task automatic test_addr_stall();
        int lat, perr; logic [31:0] rd; logic er;
        run_cmd(1'b1, 4'hA, 32'h0BADF00D, 3, 0, 1'b0, 32'h0, lat, rd, er, perr);
        checks++;
        if (lat !== 6 || perr !== 0 || er !== 1'b0 || rd !== 32'h0) begin
            failures++;
            $display("FAIL addr_stall: lat=%0d perr=%0d rd=%h err=%b want lat=6 perr=0 rd=0 err=0", lat, perr, rd, er);
        end
        tick();
    endtask

    task automatic test_back_to_back();
        logic [3:0] a [3];
        int hs[$];
        logic [31:0] rs[$];
        int k;
        for (int i = 0; i < 3; i++) a[i] = 4'($urandom);
        rom_mode = 1'b1; hready = 1'b1; k = 0;
        cmd_valid = 1'b1; cmd_write = 1'b0; cmd_addr = a[0];
        for (int c = 0; c < 16; c++) begin
            bit took;
            took = cmd_valid && cmd_ready === 1'b1;
            if (took) hs.push_back(c);
            tick();
            if (took) begin
                k++;
                if (k < 3) cmd_addr = a[k]; else cmd_valid = 1'b0;
            end
            if (rsp_valid === 1'b1) rs.push_back(rsp_rdata);
        end
        rom_mode = 1'b0;
        checks++;
        if (hs.size() != 3 || hs[1] - hs[0] != 3 || hs[2] - hs[1] != 3) begin
            failures++; $display("FAIL b2b_spacing: handshakes=%0d want 3 spaced by 3", hs.size());
        end
        checks++;
        if (rs.size() != 3) begin
            failures++; $display("FAIL b2b_rsp_count: got %0d want 3", rs.size());
        end else begin
            for (int i = 0; i < 3; i++) begin
                checks++;
                if (rs[i] !== rom_f(a[i])) begin
                    failures++; $display("FAIL b2b_rdata[%0d]: got %h want %h", i, rs[i], rom_f(a[i]));
                end
            end
        end
    endtask

    task automatic test_mid_reset();
        int lat, perr, seen; logic [31:0] rd; logic er;
        cmd_valid = 1'b1; cmd_write = 1'b1; cmd_addr = 4'h7; cmd_wdata = $urandom; hready = 1'b1;
        tick();
        cmd_valid = 1'b0;
        tick();
        hready = 1'b0; HRESET = 1'b1;
        tick();
        checks++;
        if ({HTRANS, HADDR, HWRITE, HWDATA, cmd_ready, rsp_valid, rsp_rdata, rsp_err} !== '0) begin
            failures++;
            $display("FAIL mid_reset_values: htrans=%b haddr=%h hwrite=%b hwdata=%h rdy=%b rv=%b rd=%h err=%b, want all 0",
                     HTRANS, HADDR, HWRITE, HWDATA, cmd_ready, rsp_valid, rsp_rdata, rsp_err);
        end
        HRESET = 1'b0; hready = 1'b1;
        seen = 0;
        for (int i = 0; i < 8; i++) begin tick(); if (rsp_valid !== 1'b0) seen++; end
        checks++;
        if (seen != 0) begin failures++; $display("FAIL mid_reset_no_rsp: got %0d pulses want 0", seen); end
        run_cmd(1'b0, 4'h2, 32'h0, 0, 0, 1'b0, 32'hA5A55A5A, lat, rd, er, perr);
        checks++;
        if (lat !== 3 || perr !== 0 || rd !== 32'hA5A55A5A || er !== 1'b0) begin
            failures++;
            $display("FAIL mid_reset_fresh: lat=%0d perr=%0d rd=%h err=%b want lat=3 perr=0 rd=a5a55a5a err=0", lat, perr, rd, er);
        end
        tick();
    endtask

    task automatic test_random();
        int lat, perr, wa, wd; logic [31:0] rd, d, rdat, erd; logic er, w, eer; logic [3:0] a; bit xz;
        for (int n = 0; n < 24; n++) begin
            w = 1'($urandom); a = 4'($urandom); d = $urandom; rdat = $urandom;
            wa = $urandom_range(0, 3); wd = $urandom_range(0, TMO + 1); xz = 1'($urandom);
            eer = wd >= TMO;
            erd = (w || eer) ? 32'h0 : rdat;
            run_cmd(w, a, d, wa, wd, xz, rdat, lat, rd, er, perr);
            checks++;
            if (lat !== exp_lat(wa, wd) || perr !== 0 || rd !== erd || er !== eer) begin
                failures++;
                $display("FAIL random[%0d] w=%b wa=%0d wd=%0d: lat=%0d perr=%0d rd=%h err=%b want lat=%0d perr=0 rd=%h err=%b",
                         n, w, wa, wd, lat, perr, rd, er, exp_lat(wa, wd), erd, eer);
            end
            tick();
            checks++;
            if (rsp_valid !== 1'b0 || rsp_rdata !== erd || rsp_err !== eer) begin
                failures++;
                $display("FAIL random_hold[%0d]: rv=%b rd=%h err=%b want 0 %h %b", n, rsp_valid, rsp_rdata, rsp_err, erd, eer);
            end
        end
    endtask

    initial begin
        test_reset();
        test_zero_wait_write();
        test_read_wait();
        test_timeout();
        test_addr_stall();
        test_back_to_back();
        test_mid_reset();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
